// File: rtl/gobang_pkg.sv
// Shared constants and encodings for the gobang turn controller.
package gobang_pkg;

    localparam int unsigned BOARD_N = 15;
    localparam int unsigned CELLS   = BOARD_N * BOARD_N;

    // Game result as presented on who_win
    typedef enum logic [1:0] {
        WIN_NONE  = 2'd0,
        WIN_BLACK = 2'd1,
        WIN_WHITE = 2'd2,
        WIN_DRAW  = 2'd3
    } win_t;

    // Turn sequencer states
    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_CHECK  = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

endpackage

// File: rtl/gobang_move_timer.sv
// Per-move timeout counter. Counts while run is high, clears on clr,
// holds otherwise. expire flags the last cycle of the allowed window.
module gobang_move_timer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expire
);

    logic [31:0] count;

    // Cycle counter, frozen whenever run is low and clr is not asserted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (run) begin
            count <= count + 32'd1;
        end
    end

    assign expire = run && (count == TIMEOUT_CYCLES - 32'd1);

endmodule

// File: rtl/gobang_turn_ctrl.sv
// Turn sequencer and board owner for two-player gobang.
// Optional per-move timer: define GOBANG_MOVE_TIMER_EN to add the
// TIMEOUT_CYCLES parameter and the timeout_pulse output.
module gobang_turn_ctrl
    import gobang_pkg::*;
#(
    parameter int unsigned BOARD_N = gobang_pkg::BOARD_N
`ifdef GOBANG_MOVE_TIMER_EN
    , parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000_000
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         new_game,
    input  logic                         blk_req,
    input  logic [3:0]                   blk_row,
    input  logic [3:0]                   blk_col,
    input  logic                         wht_req,
    input  logic [3:0]                   wht_row,
    input  logic [3:0]                   wht_col,
    input  logic                         win_in,
    output logic [BOARD_N*BOARD_N-1:0]   board_black,
    output logic [BOARD_N*BOARD_N-1:0]   board_white,
    output logic                         cur_black,
    output logic [3:0]                   chk_row,
    output logic [3:0]                   chk_col,
    output logic                         chk_color,
    output logic                         move_ack,
    output logic                         move_rej,
    output logic [1:0]                   who_win,
`ifdef GOBANG_MOVE_TIMER_EN
    output logic                         timeout_pulse,
`endif
    output logic [7:0]                   move_count
);

    localparam logic [4:0] SIDE5  = 5'(BOARD_N);
    localparam logic [7:0] SIDE8  = 8'(BOARD_N);
    localparam logic [7:0] CELLS8 = 8'(BOARD_N * BOARD_N);

    state_t     state;
    state_t     state_next;
    win_t       win_r;

    logic       cur_req;
    logic [3:0] cur_row;
    logic [3:0] cur_col;
    logic       in_range;
    logic [7:0] req_idx;
    logic [7:0] chk_idx;
    logic       occupied;

    logic       accept;
    logic       reject;
    logic       commit;
    logic       set_win;
    logic       set_draw;
    logic       toggle;
    logic       timeout;
    logic       expire;

    // Only the player whose turn it is gets looked at
    always_comb begin
        cur_req  = cur_black ? blk_req : wht_req;
        cur_row  = cur_black ? blk_row : wht_row;
        cur_col  = cur_black ? blk_col : wht_col;
        in_range = ({1'b0, cur_row} < SIDE5) && ({1'b0, cur_col} < SIDE5);
        // Index is formed only for in-range cells so it never exceeds the board
        req_idx  = in_range ? ({4'b0, cur_row} * SIDE8 + {4'b0, cur_col}) : '0;
        occupied = in_range && (board_black[req_idx] || board_white[req_idx]);
        chk_idx  = {4'b0, chk_row} * SIDE8 + {4'b0, chk_col};
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control decisions
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        commit     = 1'b0;
        set_win    = 1'b0;
        set_draw   = 1'b0;
        toggle     = 1'b0;
        timeout    = 1'b0;
        case (state)
            ST_WAIT: begin
                // An expiring timer forfeits the turn ahead of a same-cycle request
                if (expire) begin
                    timeout = 1'b1;
                    toggle  = 1'b1;
                end else if (cur_req) begin
                    if (in_range && !occupied) begin
                        accept     = 1'b1;
                        state_next = ST_COMMIT;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                commit     = 1'b1;
                state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (win_in) begin
                    set_win    = 1'b1;
                    state_next = ST_OVER;
                end else if (move_count == CELLS8) begin
                    set_draw   = 1'b1;
                    state_next = ST_OVER;
                end else begin
                    toggle     = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_OVER: begin
                state_next = ST_OVER;
            end
            default: begin
                state_next = ST_WAIT;
            end
        endcase
        if (new_game) begin
            state_next = ST_WAIT;
        end
    end

    // Boards, turn, result and handshake registers; new_game mirrors reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            board_black <= '0;
            board_white <= '0;
            cur_black   <= 1'b1;
            chk_row     <= '0;
            chk_col     <= '0;
            chk_color   <= 1'b0;
            move_ack    <= 1'b0;
            move_rej    <= 1'b0;
            move_count  <= '0;
            win_r       <= WIN_NONE;
        end else if (new_game) begin
            board_black <= '0;
            board_white <= '0;
            cur_black   <= 1'b1;
            chk_row     <= '0;
            chk_col     <= '0;
            chk_color   <= 1'b0;
            move_ack    <= 1'b0;
            move_rej    <= 1'b0;
            move_count  <= '0;
            win_r       <= WIN_NONE;
        end else begin
            move_ack <= accept;
            move_rej <= reject;
            if (accept) begin
                chk_row <= cur_row;
                chk_col <= cur_col;
            end
            if (commit) begin
                if (cur_black) begin
                    board_black[chk_idx] <= 1'b1;
                end else begin
                    board_white[chk_idx] <= 1'b1;
                end
                move_count <= move_count + 8'd1;
                chk_color  <= cur_black;
            end
            if (set_win) begin
                win_r <= cur_black ? WIN_BLACK : WIN_WHITE;
            end else if (set_draw) begin
                win_r <= WIN_DRAW;
            end
            if (toggle) begin
                cur_black <= ~cur_black;
            end
        end
    end

    assign who_win = win_r;

`ifdef GOBANG_MOVE_TIMER_EN
    logic timer_run;
    logic timer_clr;

    assign timer_run = (state == ST_WAIT) && !new_game;
    assign timer_clr = new_game || (state == ST_COMMIT) || (state == ST_CHECK) || timeout;

    gobang_move_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .run   (timer_run),
        .clr   (timer_clr),
        .expire(expire)
    );

    // One-cycle forfeit indication
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_pulse <= 1'b0;
        end else if (new_game) begin
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= timeout;
        end
    end
`else
    assign expire = 1'b0;
`endif

endmodule
